// File: rtl/i2s_tx_core.sv
// I2S (Philips format) transmit serializer.
// One-entry skid buffer for stereo pairs, programmable SCK divider, and an
// underrun pulse when a frame starts with nothing buffered.
module i2s_tx_core #(
    parameter int DW    = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    input  logic [DW-1:0]    sample_left,
    input  logic [DW-1:0]    sample_right,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             i2s_sck,
    output logic             i2s_ws,
    output logic             i2s_sd,
    output logic             underrun,
    output logic             busy
);

    localparam int FW = 2 * DW;
    localparam int BW = $clog2(FW);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [BW-1:0]    bit_cnt;     // slot index driven by the next slot update
    logic [FW-1:0]    shift;
    logic [FW-1:0]    buf_data;
    logic             buf_full;

    logic             accept;
    logic             slot_upd;
    logic             frame_load;
    logic             ws_next;
    logic [FW-1:0]    load_word;

    assign sample_ready = !buf_full;
    assign accept       = sample_valid && !buf_full;

    // Decide whether this clk performs a slot update and what word it shifts from.
    always_comb begin
        slot_upd = 1'b0;
        if (state == IDLE)
            slot_upd = enable;
        else
            slot_upd = enable && i2s_sck && (div_cnt == clk_div);
        frame_load = slot_upd && (bit_cnt == '0);
        load_word  = shift;
        if (frame_load)
            load_word = buf_full ? buf_data : '0;
        // WS leads the data by one slot: high from the LSB of left to the slot before the right LSB.
        ws_next = (bit_cnt >= BW'(DW - 1)) && (bit_cnt <= BW'(FW - 2));
    end

    // Skid buffer: empties on a frame load, refills on an accepted handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else begin
            if (frame_load && buf_full)
                buf_full <= 1'b0;
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= {sample_left, sample_right};
            end
        end
    end

    // Serializer FSM: divider, slot counter, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            i2s_sck  <= 1'b0;
            i2s_ws   <= 1'b0;
            i2s_sd   <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (state == RUN && !enable) begin
                state   <= IDLE;
                div_cnt <= '0;
                bit_cnt <= '0;
                i2s_sck <= 1'b0;
                i2s_ws  <= 1'b0;
                i2s_sd  <= 1'b0;
                busy    <= 1'b0;
            end else if (state == IDLE && !enable) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                i2s_sck <= 1'b0;
                i2s_ws  <= 1'b0;
                i2s_sd  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
                if (state == RUN) begin
                    if (div_cnt == clk_div) begin
                        div_cnt <= '0;
                        i2s_sck <= !i2s_sck;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                if (slot_upd) begin
                    i2s_ws   <= ws_next;
                    i2s_sd   <= load_word[FW-1];
                    shift    <= load_word << 1;
                    bit_cnt  <= (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
                    underrun <= frame_load && !buf_full;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_core.sv
// Self-checking bench for i2s_tx_core: timeline-based reference model plus
// directed literal checks and randomized traffic.
module tb_i2s_tx_core;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] clk_div;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        sample_valid;
    logic        sample_ready;
    logic        i2s_sck;
    logic        i2s_ws;
    logic        i2s_sd;
    logic        underrun;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    i2s_tx_core #(.DW(16), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clk_div(clk_div),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .underrun(underrun), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: t = clk edges since entering RUN; everything follows from t and clk_div.
    bit          m_run;
    int          m_t;
    bit          m_full;
    bit          m_ur;
    logic [31:0] m_buf;
    logic [31:0] m_fw;
    bit          m_fs;
    bit          m_acc;
    int          m_per;
    int          m_b;
    logic e_sck, e_ws, e_sd, e_ur, e_busy, e_rdy;

    always @(posedge clk) begin
        m_per = int'(clk_div) + 1;
        if (reset) begin
            m_run = 0; m_t = 0; m_full = 0; m_ur = 0; m_buf = '0; m_fw = '0;
            e_sck = 0; e_ws = 0; e_sd = 0; e_ur = 0; e_busy = 0; e_rdy = 1;
        end else begin
            m_acc = sample_valid && !m_full;
            m_fs  = 0;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1; m_t = 0; m_fs = 1;
                end
            end else if (!enable) begin
                m_run = 0;
            end else begin
                m_t++;
                m_fs = (m_t % (64 * m_per)) == 0;
            end
            if (m_fs) begin
                if (m_full) begin
                    m_fw = m_buf; m_full = 0; m_ur = 0;
                end else begin
                    m_fw = '0; m_ur = 1;
                end
            end
            if (m_acc) begin
                m_full = 1;
                m_buf  = {sample_left, sample_right};
            end
            if (m_run) begin
                m_b   = (m_t / (2 * m_per)) % 32;
                e_sck = ((m_t / m_per) % 2) == 1;
                e_sd  = m_fw[31 - m_b];
                e_ws  = (m_b >= 15) && (m_b <= 30);
                e_ur  = m_fs && m_ur;
            end else begin
                e_sck = 0; e_ws = 0; e_sd = 0; e_ur = 0;
            end
            e_busy = m_run;
            e_rdy  = !m_full;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sck", i2s_sck, e_sck);
            chk("ws", i2s_ws, e_ws);
            chk("sd", i2s_sd, e_sd);
            chk("underrun", underrun, e_ur);
            chk("busy", busy, e_busy);
            chk("sample_ready", sample_ready, e_rdy);
        end
    end

    task automatic next_rise(output bit ok);
        logic p;
        p  = i2s_sck;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i2s_sck && !p) begin
                ok = 1;
                break;
            end
            p = i2s_sck;
        end
        if (!ok) begin
            errors++;
            $display("FAIL sck_rise_timeout: got no rise expected rise at %0t", $time);
        end
    endtask

    task automatic capture(output logic [31:0] sd_w, output logic [31:0] ws_w);
        bit ok;
        sd_w = '0; ws_w = '0;
        for (int i = 0; i < 32; i++) begin
            next_rise(ok);
            sd_w = {sd_w[30:0], i2s_sd};
            ws_w = {ws_w[30:0], i2s_ws};
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        sample_left = l; sample_right = r; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
    endtask

    logic [31:0] cap_sd, cap_ws;
    bit          ok;
    int          n;
    int          seq;
    bit          rdy_prev;

    initial begin
        reset = 1; enable = 0; clk_div = 16'd1;
        sample_left = '0; sample_right = '0; sample_valid = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_ready", sample_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sck", i2s_sck, 1'b0);
        reset = 0;
        @(negedge clk);

        // Preloaded pair at clk_div=1.
        push(16'hA5A5, 16'h5A5A);
        enable = 1;
        capture(cap_sd, cap_ws);
        chk32("frame_sd", cap_sd, 32'hA5A55A5A);
        chk32("frame_ws", cap_ws, 32'h0001FFFE);

        // Empty buffer at clk_div=0: underrun each 64 clks, then a mid-frame load.
        enable = 0; clk_div = 16'd0;
        @(negedge clk);
        enable = 1;
        n = 0;
        while (!underrun && n < 200) begin @(negedge clk); n++; end
        chk("first_underrun", underrun, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!underrun && n < 500);
        chk32("frame_clks", n, 32'd64);
        repeat (10) @(negedge clk);
        push(16'h1234, 16'hABCD);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (underrun) n++;
        end
        chk32("no_underrun_after_load", n, 32'd0);

        // Drop enable in slot 10; buffered pair is kept and sent after re-enable.
        enable = 0; clk_div = 16'd1;
        @(negedge clk);
        push(16'h1357, 16'h2468);
        enable = 1;
        @(negedge clk);
        push(16'h9BDF, 16'hC0DE);
        for (int i = 0; i < 11; i++) next_rise(ok);
        enable = 0;
        @(negedge clk);
        chk("drop_sck", i2s_sck, 1'b0);
        chk("drop_busy", busy, 1'b0);
        chk("drop_ready", sample_ready, 1'b0);
        enable = 1;
        capture(cap_sd, cap_ws);
        chk32("resume_sd", cap_sd, 32'h9BDFC0DE);

        // Reset in slot 20 with the buffer full.
        enable = 0;
        @(negedge clk);
        push(16'h0F0F, 16'hF0F0);
        enable = 1;
        @(negedge clk);
        push(16'h7777, 16'h8888);
        for (int i = 0; i < 21; i++) next_rise(ok);
        reset = 1;
        @(negedge clk);
        chk("reset_ready", sample_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ws", i2s_ws, 1'b0);
        reset = 0;
        @(negedge clk);
        chk("reset_reenable_underrun", underrun, 1'b1);

        // Randomized traffic; phase 0 holds valid high with sequential pairs.
        for (int ph = 0; ph < 4; ph++) begin
            enable = 0;
            clk_div = 16'($urandom_range(0, 3));
            repeat (2) @(negedge clk);
            enable = 1;
            seq = ph * 1000;
            rdy_prev = sample_ready;
            for (int c = 0; c < 1500; c++) begin
                if (ph == 0) begin
                    if (sample_valid && rdy_prev) seq++;
                    sample_valid = 1;
                    sample_left  = 16'(seq);
                    sample_right = ~16'(seq);
                end else begin
                    sample_valid = ($urandom_range(0, 3) != 0);
                    sample_left  = 16'($urandom);
                    sample_right = 16'($urandom);
                    if ($urandom_range(0, 499) == 0) enable = 0;
                    else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
                end
                rdy_prev = sample_ready;
                @(negedge clk);
            end
            sample_valid = 0;
        end

        enable = 0;
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
